// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a shared single-port word memory.
// Grants one requester per cycle, drives the memory, and returns read data one cycle later.
module mem_arbiter #(
  parameter int unsigned DEPTH     = 100,
  parameter bit          FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_wr,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // rr_q holds the most recent winner; reset to 1 so port 0 wins the first conflict
  logic          rr_q, rr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_owner_q, rd_owner_d;
  logic          rd_oor_q, rd_oor_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic          any_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_range;
  logic [DW-1:0] rd_word;

  // Arbitration; grants are held off while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        if (FIXED_PRI || (rr_q == 1'b0)) gnt1 = 1'b1;
        else                             gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Memory drive for the granted port
  always_comb begin
    any_gnt   = gnt0 | gnt1;
    sel_we    = gnt1 ? we1    : we0;
    sel_addr  = gnt1 ? addr1  : addr0;
    sel_wdata = gnt1 ? wdata1 : wdata0;
    in_range  = (sel_addr < AW'(DEPTH));
    mem_wr      = any_gnt & sel_we & in_range;
    mem_address = any_gnt ? sel_addr  : '0;
    mem_data_in = any_gnt ? sel_wdata : '0;
  end

  // Read response path; the idle port's rdata keeps its last value
  always_comb begin
    rvalid0  = rd_pend_q & ~rd_owner_q;
    rvalid1  = rd_pend_q &  rd_owner_q;
    rd_word  = rd_oor_q ? '0 : mem_data_out;
    rdata0   = rvalid0 ? rd_word : rdata0_q;
    rdata1   = rvalid1 ? rd_word : rdata1_q;
    err0     = err0_q;
    err1     = err1_q;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
  end

  // Next-state for pointer, read pipeline and error pulses
  always_comb begin
    rr_d       = rr_q;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    rd_oor_d   = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    if (any_gnt) begin
      rr_d       = gnt1;
      rd_pend_d  = ~sel_we;
      rd_owner_d = gnt1;
      rd_oor_d   = ~in_range;
      err0_d     = gnt0 & ~in_range;
      err1_d     = gnt1 & ~in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      rr_q       <= rr_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      rd_oor_q   <= rd_oor_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference arbiter/memory predicts grants and read responses.
module tb_mem_arbiter;

  localparam int unsigned DEPTH = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_wr;
  logic [31:0] mem_address, mem_data_in, mem_data_out;

  logic        f_gnt0, f_rvalid0, f_err0, f_gnt1, f_rvalid1, f_err1, f_mem_wr;
  logic [31:0] f_rdata0, f_rdata1, f_mem_address, f_mem_data_in;

  mem_arbiter #(.DEPTH(DEPTH), .FIXED_PRI(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .mem_wr(mem_wr), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.DEPTH(DEPTH), .FIXED_PRI(1'b1)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(f_gnt0), .rvalid0(f_rvalid0), .rdata0(f_rdata0), .err0(f_err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(f_gnt1), .rvalid1(f_rvalid1), .rdata1(f_rdata1), .err1(f_err1),
    .mem_wr(f_mem_wr), .mem_address(f_mem_address), .mem_data_in(f_mem_data_in),
    .mem_data_out(32'h0)
  );

  always #5 clk = ~clk;

  // Memory: writes on falling edge, registers read data on rising edge when not writing
  logic [31:0] mem [DEPTH];
  always @(negedge clk) if (mem_wr) mem[mem_address] <= mem_data_in;
  always @(posedge clk)
    if (!mem_wr) mem_data_out <= (mem_address < DEPTH) ? mem[mem_address] : 32'hBAD0_BAD0;

  typedef struct {
    bit          rd;
    bit          port;
    logic [31:0] data;
    bit          err;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rdata [2];
  bit          m_rr;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare this cycle's response outputs against the oldest scoreboard entry
  task automatic check_resp();
    resp_t       e;
    logic        ev0, ev1, ee0, ee1;
    logic [31:0] ed0, ed1;
    ev0 = 1'b0; ev1 = 1'b0; ee0 = 1'b0; ee1 = 1'b0;
    ed0 = last_rdata[0]; ed1 = last_rdata[1];
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      if (e.port) ee1 = e.err; else ee0 = e.err;
      if (e.rd) begin
        if (e.port) begin ev1 = 1'b1; ed1 = e.data; end
        else        begin ev0 = 1'b1; ed0 = e.data; end
      end
    end
    chk("rvalid0", 32'(rvalid0), 32'(ev0));
    chk("rvalid1", 32'(rvalid1), 32'(ev1));
    chk("err0", 32'(err0), 32'(ee0));
    chk("err1", 32'(err1), 32'(ee1));
    chk("rdata0", rdata0, ed0);
    chk("rdata1", rdata1, ed1);
    last_rdata[0] = ed0;
    last_rdata[1] = ed1;
  endtask

  // One clock cycle: drive requests, check responses, predict grant and push expectation
  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic        g0, g1, w, inr;
    logic [31:0] a, d;
    resp_t       e;
    @(posedge clk);
    #1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    check_resp();
    if (r0 && r1) begin g1 = (m_rr == 1'b0); g0 = ~g1; end
    else begin g0 = r0; g1 = r1; end
    chk("gnt0", 32'(gnt0), 32'(g0));
    chk("gnt1", 32'(gnt1), 32'(g1));
    chk("fix_gnt0", 32'(f_gnt0), 32'(r0 & ~r1));
    chk("fix_gnt1", 32'(f_gnt1), 32'(r1));
    w   = g1 ? w1 : w0;
    a   = g1 ? a1 : a0;
    d   = g1 ? d1 : d0;
    inr = (a < 32'(DEPTH));
    if (g0 || g1) begin
      chk("mem_wr", 32'(mem_wr), 32'(w & inr));
      chk("mem_address", mem_address, a);
      if (w) chk("mem_data_in", mem_data_in, d);
      e.rd   = ~w;
      e.port = g1;
      e.err  = ~inr;
      e.data = (!w && inr) ? ref_mem[a] : 32'h0;
      exp_q.push_back(e);
      if (w && inr) ref_mem[a] = d;
      m_rr = g1;
    end else begin
      chk("idle_mem_wr", 32'(mem_wr), 32'h0);
      chk("idle_mem_address", mem_address, 32'h0);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt0"}, 32'(gnt0), 32'h0);
    chk({tag, "_gnt1"}, 32'(gnt1), 32'h0);
    chk({tag, "_rvalid0"}, 32'(rvalid0), 32'h0);
    chk({tag, "_rvalid1"}, 32'(rvalid1), 32'h0);
    chk({tag, "_err"}, 32'({err0, err1}), 32'h0);
    chk({tag, "_rdata0"}, rdata0, 32'h0);
    chk({tag, "_rdata1"}, rdata1, 32'h0);
    chk({tag, "_mem_wr"}, 32'(mem_wr), 32'h0);
    chk({tag, "_mem_address"}, mem_address, 32'h0);
    chk({tag, "_mem_data_in"}, mem_data_in, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    last_rdata[0] = 32'h0;
    last_rdata[1] = 32'h0;
    m_rr = 1'b1;

    // Reset with live requests: everything must stay quiet
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd5; wdata0 = 32'h1234_5678;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd6; wdata1 = 32'h0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_outputs("rst");
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;

    // Write then read back on port 0
    step(1'b1, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'd5, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd3, 32'h0);

    // Round-robin conflict with back-to-back reads
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 32'(10 + i), 32'h0, 1'b1, 1'b0, 32'(20 + i), 32'h0);
    idle();

    // Read of addr 7 followed immediately by a write to addr 7
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd7, 32'h0);
    step(1'b1, 1'b1, 32'd7, 32'h1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd7, 32'h0);
    idle();

    // Out-of-range write and reads at the boundary and at the top of the address space
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'd100, 32'h55);
    step(1'b1, 1'b0, 32'd99, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    step(1'b1, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Sustained conflict; fixed-priority instance must keep granting port 1
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'(40 + i), 32'h0, 1'b1, 1'b0, 32'(50 + i), 32'h0);
    step(1'b1, 1'b0, 32'd60, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Reset while a read is in flight: its response must never appear
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd30, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    last_rdata[0] = 32'h0;
    last_rdata[1] = 32'h0;
    m_rr = 1'b1;
    @(posedge clk);
    #2;
    check_reset_outputs("midrst_edge");
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    idle();
    step(1'b1, 1'b0, 32'd31, 32'h0, 1'b1, 1'b0, 32'd32, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'd32, 32'h0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared single-port word memory: port 0 is instruction fetch, port 1 is load/store.
- The memory writes on the falling clock edge and registers read data on the rising edge. The arbiter grants one requester per cycle, drives the memory controls, and returns read data with a one-cycle-later valid strobe.
- Out-of-range accesses are blocked and flagged.

Parameters:
- DEPTH, 100, number of 32-bit words in the memory; a legal address is 0..DEPTH-1 (word address).
- FIXED_PRI, 0, 0 = round-robin; 1 = port 1 always wins a conflict.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- req0  in  1  port 0 request, level; held until granted
- we0  in  1  port 0 write enable (1 = write, 0 = read)
- addr0  in  32  port 0 word address
- wdata0  in  32  port 0 write data
- gnt0  out  1  port 0 granted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid
- rdata0  out  32  port 0 read data
- err0  out  1  port 0 out-of-range access flag, pulse
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1  same as port 0, for port 1
- mem_wr  out  1  to memory wr
- mem_address  out  32  to memory address
- mem_data_in  out  32  to memory data_in
- mem_data_out  in  32  from memory data_out

Behaviour:
- Reset (async, rst_n=0):
  - gnt*, rvalid*, err* = 0; rdata* = 0.
  - mem_wr = 0, mem_address = 0, mem_data_in = 0.
  - Round-robin pointer set so port 0 has priority.
  - Any read in flight is discarded, with no rvalid after release.
- Arbitration (combinational, each cycle):
  - Only one port requesting: that port is granted.
  - Both requesting, FIXED_PRI=1: port 1 is granted.
  - Both requesting, FIXED_PRI=0: the port that did not win the most recent conflict-or-grant is granted. The pointer updates at posedge to the winner after any grant.
  - No request: no grant; mem_wr=0; mem_address=0.
- Memory drive in the grant cycle:
  - mem_address = winner address; mem_data_in = winner wdata.
  - mem_wr = winner we AND in-range (address < DEPTH, unsigned 32-bit compare).
- Write: completes in the grant cycle, at the memory's falling edge. No response other than the grant.
- Read pipeline:
  - On a granted read, registers rd_pend=1, rd_owner, and rd_oor at posedge.
  - The next cycle, rvalid[rd_owner]=1 for exactly one cycle.
  - rdata[rd_owner] = mem_data_out, or 0 if rd_oor.
  - rdata of the other port holds its last value.
- Back-to-back reads are supported at one per cycle, with no bubbles. The memory updates data_out at every posedge with wr=0, so the response of read N is always visible in cycle N+1, including when cycle N+1 is a write (the memory holds data_out while wr=1).
- Out-of-range:
  - The request is still granted, so the requester is not hung. The write is suppressed.
  - err* pulses 1 cycle: in the grant cycle +1 for both reads and writes, aligned with rvalid for reads.
- Grant cycle and request retention: a requester holds req/we/addr/wdata stable until the cycle gnt is seen high, then may change them at the next posedge.
- Simultaneous events: a new grant and an rvalid for an earlier read to the same or another port may occur in the same cycle; both are honoured.
- Reset mid-operation: releasing rst_n starts in the idle state; the first grant follows reset priority.
- Width: addresses are not truncated; the compare uses the full 32 bits.

Test Plan:
- Reset release, req0=1 we0=1 addr0=5 wdata0=0xDEADBEEF, then read addr0=5 -> gnt0 both cycles; rvalid0 the cycle after the read grant with rdata0=0xDEADBEEF.
- req0 and req1 both reads held 4 cycles, FIXED_PRI=0 -> grants alternate 0,1,0,1; rvalid alternates one cycle later; each rdata matches the preloaded mem[addr].
- FIXED_PRI=1, both requesting for 3 cycles -> gnt1 all 3 cycles, gnt0=0 until req1 drops.
- Port 1 reads addr 7, then port 0 writes addr 7 with 0x1 in the next cycle -> rvalid1 carries the old mem[7] during the write cycle; a subsequent read returns 0x1.
- req1 write addr1=100 (DEPTH=100), wdata1=0x55 -> gnt1=1, mem_wr=0, err1 pulse the next cycle; mem[99] and all other words are unchanged. Read addr=0xFFFFFFFF -> rvalid with rdata=0, err=1.
- Read granted, rst_n pulled low before the next posedge, then released -> no rvalid ever appears; all outputs are 0 during reset.
